// File: rtl/hamming_pkg.sv
// Hamming(7,4) bit positions and decode helpers, shared by the RX decoder and
// the future encoder/transmitter.
package hamming_pkg;

    localparam int P1_BIT = 0;
    localparam int P2_BIT = 1;
    localparam int D1_BIT = 2;
    localparam int P4_BIT = 3;
    localparam int D2_BIT = 4;
    localparam int D3_BIT = 5;
    localparam int D4_BIT = 6;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    typedef struct packed {
        logic              corrected;
        logic [DATA_W-1:0] data;
    } dec_word_t;

    function automatic logic [2:0] hamming74_syndrome(input logic [CW_W-1:0] cw);
        logic s1, s2, s4;
        s1 = cw[P1_BIT] ^ cw[D1_BIT] ^ cw[D2_BIT] ^ cw[D4_BIT];
        s2 = cw[P2_BIT] ^ cw[D1_BIT] ^ cw[D3_BIT] ^ cw[D4_BIT];
        s4 = cw[P4_BIT] ^ cw[D2_BIT] ^ cw[D3_BIT] ^ cw[D4_BIT];
        return {s4, s2, s1};
    endfunction

    // Returns {corrected, payload}; a nonzero syndrome names the flipped position.
    function automatic logic [DATA_W:0] hamming74_correct(input logic [CW_W-1:0] cw);
        logic [2:0]      syn;
        logic [CW_W-1:0] fixed;
        syn   = hamming74_syndrome(cw);
        fixed = cw;
        if (syn != 3'd0)
            fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
        return {(syn != 3'd0), fixed[D4_BIT], fixed[D3_BIT], fixed[D2_BIT], fixed[D1_BIT]};
    endfunction

endpackage

// File: rtl/hamming_sync_fifo.sv
// DEPTH x W synchronous FIFO; head word is read combinationally from storage.
module hamming_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push, w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hamming_rx_decoder.sv
// Hamming(7,4) receive decoder: capture, single-error correction, payload FIFO
// with valid/ready output, sticky overflow and saturating statistics.
module hamming_rx_decoder
    import hamming_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [6:0]       code_in,
    input  logic             code_valid,
    output logic [3:0]       data_out,
    output logic             corrected_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] drop_count,
    input  logic             clear_stats
);
    logic [CW_W-1:0]       r_cw_q;
    logic                  r_cw_v;
    logic                  r_overflow;
    logic [CNT_W-1:0]      r_corr_cnt, r_drop_cnt;

    dec_word_t             w_dec, w_head;
    logic                  w_push_req, w_pop_req, w_pop_ok, w_push_ok, w_drop;
    logic                  w_full, w_empty;
    logic [$clog2(DEPTH):0] w_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cw_q <= '0;
            r_cw_v <= 1'b0;
        end else if (ena) begin
            r_cw_v <= code_valid;
            if (code_valid)
                r_cw_q <= code_in;
        end
    end

    assign w_dec      = dec_word_t'(hamming74_correct(r_cw_q));
    assign w_push_req = ena & r_cw_v;
    assign w_pop_req  = ena & out_ready;
    assign w_pop_ok   = w_pop_req & ~w_empty;
    assign w_drop     = w_push_req & w_full & ~w_pop_ok;
    assign w_push_ok  = w_push_req & ~w_drop;

    hamming_sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(dec_word_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_wdata (w_dec),
        .i_pop   (w_pop_req),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign data_out      = w_head.data;
    assign corrected_out = w_head.corrected;
    assign out_valid     = (w_count != '0);

    // Clear wins over any same-cycle increment or overflow set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_corr_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (ena) begin
            if (clear_stats) begin
                r_overflow <= 1'b0;
                r_corr_cnt <= '0;
                r_drop_cnt <= '0;
            end else begin
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drop_cnt != '1)
                        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
                if (w_push_ok && w_dec.corrected && (r_corr_cnt != '1))
                    r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
        end
    end

    assign overflow   = r_overflow;
    assign corr_count = r_corr_cnt;
    assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Directed bench for hamming_rx_decoder; a second instance with CNT_W=2 checks saturation.
module tb_hamming_rx_decoder;

    logic       clk = 1'b0;
    logic       rst_n, ena, code_valid, out_ready, clear_stats;
    logic [6:0] code_in;

    logic [3:0] data_out;
    logic       corrected_out, out_valid, overflow;
    logic [7:0] corr_count, drop_count;

    logic [3:0] s_data;
    logic       s_corr, s_valid, s_ovf;
    logic [1:0] s_corr_cnt, s_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hamming_rx_decoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .code_in(code_in), .code_valid(code_valid),
        .data_out(data_out), .corrected_out(corrected_out), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .corr_count(corr_count),
        .drop_count(drop_count), .clear_stats(clear_stats)
    );

    hamming_rx_decoder #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .code_in(code_in), .code_valid(code_valid),
        .data_out(s_data), .corrected_out(s_corr), .out_valid(s_valid),
        .out_ready(out_ready), .overflow(s_ovf), .corr_count(s_corr_cnt),
        .drop_count(s_drop_cnt), .clear_stats(clear_stats)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] cw);
        code_in    = cw;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    // Hand-encoded clean codewords {d4,d3,d2,d1} payloads: 1, 8, 2, F, 0, B
    logic [6:0] fill_cw [6] = '{7'b0000111, 7'b1001011, 7'b0011001,
                                7'b1111111, 7'b0000000, 7'b1010101};
    logic [3:0] fill_pl [6] = '{4'h1, 4'h8, 4'h2, 4'hF, 4'h0, 4'hB};

    // Single-error table: {codeword, expected payload, expected corrected}
    logic [6:0] vec_cw   [5] = '{7'b1010101, 7'b1000101, 7'b1000000, 7'b1111110, 7'b0000100};
    logic [3:0] vec_pl   [5] = '{4'hB, 4'hB, 4'h0, 4'hF, 4'h0};
    logic       vec_corr [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    int exp_corr;

    initial begin
        rst_n = 1'b0; ena = 1'b1; code_valid = 1'b0; out_ready = 1'b0;
        clear_stats = 1'b0; code_in = '0;
        exp_corr = 0;
        tick(); tick();
        chk("rst out_valid", out_valid, 0);
        chk("rst data_out", data_out, 0);
        chk("rst corrected_out", corrected_out, 0);
        chk("rst overflow", overflow, 0);
        chk("rst corr_count", corr_count, 0);
        chk("rst drop_count", drop_count, 0);
        rst_n = 1'b1;
        tick();

        // Decode table: latency then one word at a time
        for (int i = 0; i < 5; i++) begin
            send(vec_cw[i]);
            chk("latency edge N", out_valid, 0);
            tick();
            if (vec_corr[i]) exp_corr++;
            chk("latency edge N+1", out_valid, 1);
            chk("dec data_out", data_out, vec_pl[i]);
            chk("dec corrected_out", corrected_out, vec_corr[i]);
            chk("dec corr_count", corr_count, exp_corr);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("pop to empty", out_valid, 0);
        end

        // Overflow: six words into a 4-deep FIFO with no consumer
        for (int i = 0; i < 6; i++) send(fill_cw[i]);
        tick();
        chk("ovf overflow", overflow, 1);
        chk("ovf drop_count", drop_count, 2);
        chk("ovf corr_count", corr_count, exp_corr);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf valid", out_valid, 1);
            chk("ovf drain order", data_out, fill_pl[i]);
            tick();
        end
        chk("ovf drained", out_valid, 0);
        out_ready = 1'b0;

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) send(fill_cw[i]);
        tick();
        send(fill_cw[4]);
        out_ready = 1'b1;
        tick();
        chk("fullpp drop_count", drop_count, 2);
        chk("fullpp overflow sticky", overflow, 1);
        for (int i = 1; i < 5; i++) begin
            chk("fullpp valid", out_valid, 1);
            chk("fullpp drain order", data_out, fill_pl[i]);
            tick();
        end
        chk("fullpp drained", out_valid, 0);
        out_ready = 1'b0;

        // Asynchronous reset with words buffered
        for (int i = 0; i < 3; i++) send(fill_cw[i]);
        tick();
        chk("prereset valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst overflow", overflow, 0);
        chk("async rst drop_count", drop_count, 0);
        chk("async rst corr_count", corr_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ena=0 blocks capture
        ena = 1'b0;
        code_in = 7'b1000101; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        tick();
        ena = 1'b1;
        tick(); tick();
        chk("ena0 no capture", out_valid, 0);
        chk("ena0 corr_count", corr_count, 0);

        // ena=0 blocks pop
        send(7'b1111111);
        tick();
        out_ready = 1'b1;
        ena = 1'b0;
        tick();
        chk("ena0 no pop", out_valid, 1);
        ena = 1'b1;
        tick();
        chk("ena1 pop", out_valid, 0);

        // Corrected words: main counter counts, 2-bit counter saturates
        for (int i = 0; i < 5; i++) begin
            send(7'b1000101);
            tick();
            chk("corr count", corr_count, i + 1);
            chk("sat corr count", s_corr_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        tick();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear corr_count", corr_count, 0);
        chk("clear sat corr_count", s_corr_cnt, 0);

        // Clear beats a same-edge increment
        send(7'b1000101);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear priority", corr_count, 0);
        tick();
        chk("after clear", corr_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
